// File: rtl/mic_packer_pkg.sv
// rtl/mic_packer_pkg.sv - shared types and constants for the microphone RAM packer
// Contents:
//   SAMPLE_W     sample width; two samples fill one 32-bit RAM word
//   BYTE_EN_ALL  byteenable value used for every RAM write
//   state_t      packer FSM states {FILL, STALL}
//   half_words() number of words in one ping-pong half for a given address width
package mic_packer_pkg;

  localparam int SAMPLE_W = 16;
  localparam logic [3:0] BYTE_EN_ALL = 4'hF;

  typedef enum logic {
    FILL  = 1'b0,
    STALL = 1'b1
  } state_t;

  function automatic int half_words(input int addr_w);
    return 1 << (addr_w - 1);
  endfunction

endpackage

// File: rtl/mic_ram_packer_if.sv
// rtl/mic_ram_packer_if.sv - sample stream and RAM second-port bus bundle
// Signals:
//   s_valid, s_data      incoming microphone samples (no backpressure)
//   ram_address          RAM word address
//   ram_chipselect       write strobe qualifier
//   ram_write            write strobe
//   ram_clken            RAM clock enable
//   ram_byteenable       byte enables
//   ram_writedata        {second sample, first sample}
// Modports:
//   master  the packer: consumes samples, drives the RAM port
//   slave   the environment: produces samples, observes the RAM port
interface mic_ram_packer_if #(
  parameter int ADDR_W = 9
);
  import mic_packer_pkg::*;

  logic                s_valid;
  logic [SAMPLE_W-1:0] s_data;
  logic [ADDR_W-1:0]   ram_address;
  logic                ram_chipselect;
  logic                ram_write;
  logic                ram_clken;
  logic [3:0]          ram_byteenable;
  logic [31:0]         ram_writedata;

  modport master (
    input  s_valid, s_data,
    output ram_address, ram_chipselect, ram_write, ram_clken,
           ram_byteenable, ram_writedata
  );

  modport slave (
    output s_valid, s_data,
    input  ram_address, ram_chipselect, ram_write, ram_clken,
           ram_byteenable, ram_writedata
  );

endinterface

// File: rtl/mic_ram_packer.sv
// rtl/mic_ram_packer.sv - packs 16-bit samples into 32-bit words in a ping-pong RAM buffer
// Ports:
//   clk_clk        system clock (Nios clock domain)
//   reset_reset_n  asynchronous active-low reset
//   bus            mic_ram_packer_if.master: sample stream in, RAM second port out
//   irq_ack        one-cycle pulse releasing the half currently reported
//   irq_out        level interrupt, high while a completed half awaits the CPU
//   ready_half     the half the CPU should read while irq_out is high
//   drop_count     saturating count of samples dropped while both halves are full
module mic_ram_packer
  import mic_packer_pkg::*;
#(
  parameter int ADDR_W = 9
) (
  input  logic                clk_clk,
  input  logic                reset_reset_n,
  mic_ram_packer_if.master    bus,
  input  logic                irq_ack,
  output logic                irq_out,
  output logic                ready_half,
  output logic [15:0]         drop_count
);

  localparam int IDX_W = ADDR_W - 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(half_words(ADDR_W) - 1);

  state_t              state, state_next;
  logic                fill_half;
  logic [IDX_W-1:0]    word_idx;
  logic                phase;
  logic [SAMPLE_W-1:0] low_reg;
  logic                irq_pending;
  logic                irq_set_d;
  logic                wr_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         data_q;

  logic take_low, pair_wr, half_done, irq_set, irq_clr, stall_exit, drop;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) state <= FILL;
    else                state <= state_next;
  end

  always_comb begin
    state_next = state;
    take_low   = 1'b0;
    pair_wr    = 1'b0;
    half_done  = 1'b0;
    irq_set    = 1'b0;
    irq_clr    = 1'b0;
    stall_exit = 1'b0;
    drop       = 1'b0;
    case (state)
      FILL: begin
        take_low  = bus.s_valid && !phase;
        pair_wr   = bus.s_valid && phase;
        half_done = pair_wr && (word_idx == LAST_IDX);
        if (half_done) begin
          // An ack landing with the completion frees the reported half just in time.
          if (!irq_pending || irq_ack) irq_set = 1'b1;
          else                         state_next = STALL;
        end else if (irq_ack && irq_pending) begin
          irq_clr = 1'b1;
        end
      end
      STALL: begin
        drop = bus.s_valid;
        if (irq_ack) begin
          stall_exit = 1'b1;
          state_next = FILL;
        end
      end
      default: state_next = FILL;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      fill_half   <= 1'b0;
      word_idx    <= '0;
      phase       <= 1'b0;
      low_reg     <= '0;
      irq_pending <= 1'b0;
      irq_set_d   <= 1'b0;
      irq_out     <= 1'b0;
      ready_half  <= 1'b0;
      drop_count  <= '0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
    end else begin
      wr_q      <= pair_wr;
      irq_set_d <= irq_set;
      if (take_low) begin
        low_reg <= bus.s_data;
        phase   <= 1'b1;
      end
      if (pair_wr) begin
        addr_q   <= {fill_half, word_idx};
        data_q   <= {bus.s_data, low_reg};
        phase    <= 1'b0;
        // Wraps to 0 on the last word of a half, both on flip and on stall.
        word_idx <= word_idx + 1'b1;
      end
      if (irq_set) begin
        irq_pending <= 1'b1;
        ready_half  <= fill_half;
        fill_half   <= ~fill_half;
      end
      if (irq_clr) irq_pending <= 1'b0;
      if (stall_exit) begin
        ready_half <= fill_half;
        fill_half  <= ~fill_half;
        phase      <= 1'b0;
      end
      if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
      // Rise is delayed one cycle so the final word is in RAM first; fall is immediate.
      if (irq_clr)        irq_out <= 1'b0;
      else if (irq_set_d) irq_out <= 1'b1;
    end
  end

  assign bus.ram_address    = addr_q;
  assign bus.ram_chipselect = wr_q;
  assign bus.ram_write      = wr_q;
  assign bus.ram_clken      = 1'b1;
  assign bus.ram_byteenable = BYTE_EN_ALL;
  assign bus.ram_writedata  = data_q;

endmodule

// File: tb/tb_mic_ram_packer.sv
// tb/tb_mic_ram_packer.sv - directed self-checking bench for mic_ram_packer
module tb_mic_ram_packer;
  import mic_packer_pkg::*;

  logic        clk_clk = 1'b0;
  logic        reset_reset_n = 1'b0;
  logic        irq_ack = 1'b0;
  logic        irq_out;
  logic        ready_half;
  logic [15:0] drop_count;

  int checks = 0;
  int errors = 0;
  int long_strobes = 0;
  logic prev_write = 1'b0;

  mic_ram_packer_if #(.ADDR_W(9)) bus ();

  mic_ram_packer #(.ADDR_W(9)) dut (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .bus           (bus),
    .irq_ack       (irq_ack),
    .irq_out       (irq_out),
    .ready_half    (ready_half),
    .drop_count    (drop_count)
  );

  always #5 clk_clk = ~clk_clk;

  always @(negedge clk_clk) begin
    if (bus.ram_write && prev_write) long_strobes++;
    prev_write = bus.ram_write;
  end

  task automatic step(input logic v, input logic [15:0] d, input logic ack);
    bus.s_valid = v;
    bus.s_data  = d;
    irq_ack     = ack;
    @(posedge clk_clk);
    #1;
    bus.s_valid = 1'b0;
    irq_ack     = 1'b0;
  endtask

  task automatic send_n(input int start, input int n);
    for (int i = 0; i < n; i++) step(1'b1, 16'(start + i), 1'b0);
  endtask

  task automatic do_reset();
    reset_reset_n = 1'b0;
    @(posedge clk_clk);
    #1;
    reset_reset_n = 1'b1;
    @(posedge clk_clk);
    #1;
  endtask

  task automatic test_reset();
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    do_reset();
    checks++;
    if ({bus.ram_address, bus.ram_chipselect, bus.ram_write, bus.ram_writedata,
         irq_out, ready_half, drop_count} !== '0) begin
      errors++;
      $display("FAIL reset_zero got addr=%h cs=%b wr=%b data=%h irq=%b rh=%b dc=%h required all 0",
               bus.ram_address, bus.ram_chipselect, bus.ram_write, bus.ram_writedata,
               irq_out, ready_half, drop_count);
    end
    checks++;
    if (bus.ram_clken !== 1'b1 || bus.ram_byteenable !== 4'hF) begin
      errors++;
      $display("FAIL reset_const got clken=%b be=%h required 1 F", bus.ram_clken, bus.ram_byteenable);
    end
  endtask

  task automatic test_basic();
    do_reset();
    step(1'b1, 16'h0001, 1'b0);
    checks++;
    if (bus.ram_write !== 1'b0) begin
      errors++; $display("FAIL basic_nowrite got %b required 0", bus.ram_write);
    end
    step(1'b1, 16'h0002, 1'b0);
    checks++;
    if (bus.ram_write !== 1'b1 || bus.ram_chipselect !== 1'b1 ||
        bus.ram_address !== 9'd0 || bus.ram_writedata !== 32'h00020001) begin
      errors++;
      $display("FAIL basic_w0 got wr=%b cs=%b addr=%0d data=%h required 1 1 0 00020001",
               bus.ram_write, bus.ram_chipselect, bus.ram_address, bus.ram_writedata);
    end
    step(1'b1, 16'h0003, 1'b0);
    checks++;
    if (bus.ram_write !== 1'b0) begin
      errors++; $display("FAIL basic_strobe got %b required 0", bus.ram_write);
    end
    step(1'b1, 16'h0004, 1'b0);
    checks++;
    if (bus.ram_write !== 1'b1 || bus.ram_address !== 9'd1 || bus.ram_writedata !== 32'h00040003) begin
      errors++;
      $display("FAIL basic_w1 got wr=%b addr=%0d data=%h required 1 1 00040003",
               bus.ram_write, bus.ram_address, bus.ram_writedata);
    end
    step(1'b0, 16'h0000, 1'b0);
    checks++;
    if (bus.ram_write !== 1'b0 || irq_out !== 1'b0) begin
      errors++; $display("FAIL basic_idle got wr=%b irq=%b required 0 0", bus.ram_write, irq_out);
    end
  endtask

  task automatic test_half_and_ack();
    do_reset();
    send_n(0, 511);
    step(1'b1, 16'd511, 1'b0);
    checks++;
    if (bus.ram_write !== 1'b1 || bus.ram_address !== 9'd255 ||
        bus.ram_writedata !== 32'h01FF01FE || irq_out !== 1'b0) begin
      errors++;
      $display("FAIL half_last got wr=%b addr=%0d data=%h irq=%b required 1 255 01FF01FE 0",
               bus.ram_write, bus.ram_address, bus.ram_writedata, irq_out);
    end
    step(1'b0, 16'h0000, 1'b0);
    checks++;
    if (irq_out !== 1'b1 || ready_half !== 1'b0) begin
      errors++; $display("FAIL half_irq got irq=%b rh=%b required 1 0", irq_out, ready_half);
    end
    send_n(512, 2);
    checks++;
    if (bus.ram_write !== 1'b1 || bus.ram_address !== 9'd256 || bus.ram_writedata !== 32'h02010200) begin
      errors++;
      $display("FAIL half_next got wr=%b addr=%0d data=%h required 1 256 02010200",
               bus.ram_write, bus.ram_address, bus.ram_writedata);
    end
    step(1'b0, 16'h0000, 1'b1);
    checks++;
    if (irq_out !== 1'b0) begin
      errors++; $display("FAIL ack_fall got irq=%b required 0", irq_out);
    end
    send_n(514, 510);
    step(1'b0, 16'h0000, 1'b0);
    checks++;
    if (irq_out !== 1'b1 || ready_half !== 1'b1) begin
      errors++; $display("FAIL half1_irq got irq=%b rh=%b required 1 1", irq_out, ready_half);
    end
    send_n(16'h1000, 2);
    checks++;
    if (bus.ram_write !== 1'b1 || bus.ram_address !== 9'd0 || bus.ram_writedata !== 32'h10011000) begin
      errors++;
      $display("FAIL half1_wrap got wr=%b addr=%0d data=%h required 1 0 10011000",
               bus.ram_write, bus.ram_address, bus.ram_writedata);
    end
  endtask

  task automatic test_stall();
    do_reset();
    send_n(0, 1024);
    checks++;
    if (dut.state !== STALL || irq_out !== 1'b1 || ready_half !== 1'b0) begin
      errors++;
      $display("FAIL stall_enter got st=%b irq=%b rh=%b required 1 1 0", dut.state, irq_out, ready_half);
    end
    step(1'b0, 16'h0000, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 16'(16'h3000 + i), 1'b0);
      checks++;
      if (bus.ram_write !== 1'b0) begin
        errors++; $display("FAIL stall_nowrite got %b required 0 at drop %0d", bus.ram_write, i);
      end
    end
    checks++;
    if (drop_count !== 16'd10 || dut.state !== STALL) begin
      errors++; $display("FAIL stall_drops got dc=%0d st=%b required 10 1", drop_count, dut.state);
    end
    step(1'b0, 16'h0000, 1'b1);
    checks++;
    if (ready_half !== 1'b1 || irq_out !== 1'b1 || dut.state !== FILL) begin
      errors++;
      $display("FAIL stall_ack got rh=%b irq=%b st=%b required 1 1 0", ready_half, irq_out, dut.state);
    end
    step(1'b1, 16'hAAAA, 1'b0);
    step(1'b1, 16'hBBBB, 1'b0);
    checks++;
    if (bus.ram_write !== 1'b1 || bus.ram_address !== 9'd0 || bus.ram_writedata !== 32'hBBBBAAAA) begin
      errors++;
      $display("FAIL stall_resume got wr=%b addr=%0d data=%h required 1 0 BBBBAAAA",
               bus.ram_write, bus.ram_address, bus.ram_writedata);
    end
  endtask

  task automatic test_ack_same_cycle();
    do_reset();
    send_n(0, 1023);
    step(1'b1, 16'd1023, 1'b1);
    checks++;
    if (dut.state !== FILL || bus.ram_address !== 9'd511 || ready_half !== 1'b1 || irq_out !== 1'b1) begin
      errors++;
      $display("FAIL same_ack got st=%b addr=%0d rh=%b irq=%b required 0 511 1 1",
               dut.state, bus.ram_address, ready_half, irq_out);
    end
    step(1'b0, 16'h0000, 1'b0);
    checks++;
    if (irq_out !== 1'b1) begin
      errors++; $display("FAIL same_ack_irq got %b required 1", irq_out);
    end
    send_n(16'h0042, 2);
    checks++;
    if (bus.ram_address !== 9'd0 || bus.ram_writedata !== 32'h00430042 || drop_count !== 16'd0) begin
      errors++;
      $display("FAIL same_ack_next got addr=%0d data=%h dc=%0d required 0 00430042 0",
               bus.ram_address, bus.ram_writedata, drop_count);
    end
  endtask

  task automatic test_saturate_and_reset();
    do_reset();
    send_n(0, 1024);
    send_n(0, 65534);
    checks++;
    if (drop_count !== 16'hFFFE) begin
      errors++; $display("FAIL sat_fffe got %h required FFFE", drop_count);
    end
    send_n(0, 5);
    checks++;
    if (drop_count !== 16'hFFFF) begin
      errors++; $display("FAIL sat_ffff got %h required FFFF", drop_count);
    end
    step(1'b0, 16'h0000, 1'b1);
    step(1'b1, 16'h5555, 1'b0);
    reset_reset_n = 1'b0;
    #1;
    checks++;
    if ({bus.ram_address, bus.ram_chipselect, bus.ram_write, bus.ram_writedata,
         irq_out, ready_half, drop_count} !== '0 || bus.ram_clken !== 1'b1 ||
        bus.ram_byteenable !== 4'hF) begin
      errors++;
      $display("FAIL midreset got addr=%h wr=%b data=%h irq=%b rh=%b dc=%h required reset values",
               bus.ram_address, bus.ram_write, bus.ram_writedata, irq_out, ready_half, drop_count);
    end
    @(posedge clk_clk);
    #1;
    reset_reset_n = 1'b1;
    step(1'b1, 16'h0007, 1'b0);
    step(1'b1, 16'h0008, 1'b0);
    checks++;
    if (bus.ram_address !== 9'd0 || bus.ram_writedata !== 32'h00080007) begin
      errors++;
      $display("FAIL midreset_pair got addr=%0d data=%h required 0 00080007",
               bus.ram_address, bus.ram_writedata);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_half_and_ack();
    test_stall();
    test_ack_same_cycle();
    test_saturate_and_reset();
    checks++;
    if (long_strobes !== 0) begin
      errors++; $display("FAIL strobe_width got %0d multi-cycle strobes required 0", long_strobes);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mic_ram_packer.md
# mic_ram_packer

Packs a stream of 16-bit microphone samples into 32-bit words and writes them into the Nios system's shared on-chip RAM through its second port (`ram_block_s2_*`). The RAM is used as a ping-pong buffer: while the CPU drains one half, this block fills the other. It raises a level interrupt on `ext_irq_adapter_new_signal` whenever a half is complete. Samples that arrive while both halves are full are dropped and counted.

## Interface
Parameters:
- `ADDR_W`, 9 — RAM word-address width; each half holds `HALF_WORDS = 2**(ADDR_W-1)` words (256 at default).
- `SAMPLE_W`, 16 — sample width; fixed so that two samples fill one 32-bit word.

Ports:
- `clk_clk`  in  1  system clock, the same clock as the Nios system.
- `reset_reset_n`  in  1  asynchronous, active-low reset.
- `s_valid`  in  1  a sample is present this cycle; there is no backpressure.
- `s_data`  in  16  sample value.
- `irq_ack`  in  1  one-cycle pulse from a CPU PIO; releases the half currently reported.
- `ram_address`  out  ADDR_W  word address; maps to `ram_block_s2_address`.
- `ram_chipselect`  out  1  write strobe qualifier.
- `ram_write`  out  1  write strobe.
- `ram_clken`  out  1  tied to 1 after reset.
- `ram_byteenable`  out  4  always 4'hF.
- `ram_writedata`  out  32  {second sample, first sample}.
- `irq_out`  out  1  level interrupt; drives `ext_irq_adapter_new_signal`.
- `ready_half`  out  1  the half the CPU should read while `irq_out` is high.
- `drop_count`  out  16  number of dropped samples; saturates at 16'hFFFF.

## Operation
- Internal state: `fill_half`, `word_idx` [ADDR_W-2:0], `phase`, `low_reg`, `irq_pending`, FSM {FILL, STALL}.
- Reset values: every output is 0 except `ram_byteenable`=4'hF and `ram_clken`=1. `fill_half`=0, `phase`=0, FSM=FILL.
- FILL, `s_valid` with `phase`=0: `low_reg` <= `s_data`; `phase` <= 1.
- FILL, `s_valid` with `phase`=1:
  - Issue a write of {`s_data`, `low_reg`} to {`fill_half`, `word_idx`}.
  - `phase` <= 0; `word_idx` increments.
- Half complete (write to `word_idx`=HALF_WORDS-1):
  - If `irq_pending`=0, or `irq_ack` arrives in the same cycle: `irq_pending` <= 1, `ready_half` <= `fill_half`, `fill_half` flips, `word_idx` <= 0.
  - Otherwise: go to STALL with `word_idx` <= 0. The just-filled half is held as pending-next.
- FILL, `irq_ack` with no completion in the same cycle: `irq_pending` <= 0.
- `irq_ack` while `irq_pending`=0: ignored.
- STALL: every `s_valid` is dropped and `drop_count` increments (saturating).
- STALL, `irq_ack`:
  - `ready_half` <= `fill_half` (the held full half); `irq_pending` stays 1.
  - `fill_half` flips to the freed half; `phase` <= 0; return to FILL.
  - A sample arriving in the ack cycle is dropped and counted.
- `irq_out` = `irq_pending` (registered).

## Timing
- The write appears on the RAM port in the cycle after the second sample of a pair is accepted. `ram_chipselect` and `ram_write` are high for exactly 1 cycle per word.
- Back-to-back `s_valid` is legal; it produces at most one write every 2 cycles.
- `irq_out` rises in the cycle after the ram write of the half's final word, so that word is in RAM before the CPU sees the interrupt.
- `irq_out` falls in the cycle after `irq_ack` (FILL case).
- Asserting reset mid-word or mid-half aborts the operation immediately. The partial pair and the partial half are discarded, and `drop_count` is cleared.

## Structure
- Package `mic_packer_pkg`: FSM state enum {FILL, STALL}, `SAMPLE_W`, the byteenable constant 4'hF, and a `HALF_WORDS` function.
- Single module; there is no natural sub-module. The saturating counter stays inline.

## Test plan
- After reset, 4 samples 16'h0001..16'h0004 -> writes 32'h00020001 @ 0 and 32'h00040003 @ 1; each strobe is 1 cycle; `irq_out`=0.
- 512 samples -> the write to address 255 is followed one cycle later by `irq_out`=1 with `ready_half`=0; the next write goes to address 256.
- Pulse `irq_ack` -> `irq_out`=0 next cycle. A further 512 samples -> `irq_out`=1 with `ready_half`=1, and the following write wraps to address 0.
- No ack; fill both halves, then send 10 more samples -> no writes occur, `drop_count`=10, FSM=STALL. Then `irq_ack` -> `ready_half`=1, `irq_out` stays 1, and the next pair is written to address 0.
- `irq_ack` in the same cycle as the half-completing write with `irq_pending`=1 -> no stall; `ready_half` flips; `irq_out` stays 1.
- Force `drop_count` to 16'hFFFE, then drop 5 samples -> `drop_count`=16'hFFFF. Assert reset for 1 cycle mid-pair -> all outputs return to their reset values.
